// File: rtl/ps2_scan_sequencer_if.sv
// Byte-in / matrix-write-out bundle between PS/2 receiver, sequencer and key matrix.
// Pure wiring, no latency.
// No backpressure: bytes are pushed, matrix writes are fire-and-forget.
interface ps2_scan_sequencer_if;
  logic       ce;
  logic       rx_strobe;
  logic [7:0] rx_data;
  logic       clear;
  logic       strobe;
  logic       pressed;
  logic [7:0] code;
  logic       busy;
  logic       dropped;

  modport master (
    output ce, rx_strobe, rx_data, clear,
    input  strobe, pressed, code, busy, dropped
  );

  modport slave (
    input  ce, rx_strobe, rx_data, clear,
    output strobe, pressed, code, busy, dropped
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// Turns PS/2 scan bytes (with F0/E0/E1 prefixes) into key-matrix writes; owns release-all sweeps.
// Latency: one cycle from sampled rx_strobe to registered strobe/code/pressed.
// No backpressure: one-entry hold absorbs a byte during a sweep, further bytes are dropped and flagged.
module ps2_scan_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd60000
) (
  input  logic                   clock,
  input  logic                   reset,
  ps2_scan_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_SWEEP, ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK, ST_SKIP
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  sweep_cnt_q, sweep_cnt_d;
  logic [2:0]  skip_cnt_q, skip_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  hold_dat_q, hold_dat_d;
  logic        strobe_q, strobe_d;
  logic        pressed_q, pressed_d;
  logic [7:0]  code_q, code_d;
  logic        dropped_q, dropped_d;

  logic        byte_vld;
  logic [7:0]  byte_dat;
  logic        in_prefix;

  assign in_prefix = (state_q == ST_BREAK) || (state_q == ST_EXT) ||
                     (state_q == ST_EXT_BREAK) || (state_q == ST_SKIP);

  // Next-state: sweep engine, hold register, prefix decoder and prefix timeout.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    skip_cnt_d  = skip_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_dat_d  = hold_dat_q;
    strobe_d    = 1'b0;
    pressed_d   = pressed_q;
    code_d      = code_q;
    dropped_d   = 1'b0;
    byte_vld    = 1'b0;
    byte_dat    = 8'h00;

    if (bus.clear || state_q == ST_SWEEP) begin
      // clear wins over everything, including the sweep step of this cycle
      if (bus.clear) begin
        state_d     = ST_SWEEP;
        sweep_cnt_d = 7'h00;
      end else begin
        strobe_d    = 1'b1;
        pressed_d   = 1'b1;
        code_d      = {1'b0, sweep_cnt_q};
        sweep_cnt_d = sweep_cnt_q + 7'h01;
        if (sweep_cnt_q == 7'h7F) begin
          state_d = ST_IDLE;
        end
      end
      // bytes arriving while sweeping are parked; a second one is lost
      if (bus.rx_strobe) begin
        if (hold_vld_q) begin
          dropped_d = 1'b1;
        end else begin
          hold_vld_d = 1'b1;
          hold_dat_d = bus.rx_data;
        end
      end
    end else begin
      // parked byte goes first; a byte arriving now takes its slot
      if (hold_vld_q) begin
        byte_vld = 1'b1;
        byte_dat = hold_dat_q;
        if (bus.rx_strobe) begin
          hold_dat_d = bus.rx_data;
        end else begin
          hold_vld_d = 1'b0;
        end
      end else if (bus.rx_strobe) begin
        byte_vld = 1'b1;
        byte_dat = bus.rx_data;
      end

      if (byte_vld) begin
        if (byte_dat == 8'h00 || byte_dat == 8'hFF) begin
          state_d     = ST_SWEEP;
          sweep_cnt_d = 7'h00;
        end else if (state_q == ST_SKIP) begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) begin
            state_d = ST_IDLE;
          end
        end else if (byte_dat == 8'hF0) begin
          if (state_q == ST_IDLE) begin
            state_d = ST_BREAK;
          end else if (state_q == ST_EXT) begin
            state_d = ST_EXT_BREAK;
          end
        end else if (byte_dat == 8'hE0) begin
          state_d = ST_EXT;
        end else if (byte_dat == 8'hE1) begin
          state_d    = ST_SKIP;
          skip_cnt_d = 3'd7;
        end else if (!byte_dat[7]) begin
          strobe_d  = 1'b1;
          code_d    = byte_dat;
          pressed_d = (state_q == ST_BREAK) || (state_q == ST_EXT_BREAK);
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (bus.ce && in_prefix) begin
        if (tmo_cnt_q == TIMEOUT - 16'd1) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
    end

    // timeout restarts on any accepted byte or any state change
    if (byte_vld || state_d != state_q) begin
      tmo_cnt_d = 16'd0;
    end
  end

  // State and output registers; reset lands in a fresh sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SWEEP;
      sweep_cnt_q <= 7'h00;
      skip_cnt_q  <= 3'd0;
      tmo_cnt_q   <= 16'd0;
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= 8'h00;
      strobe_q    <= 1'b0;
      pressed_q   <= 1'b1;
      code_q      <= 8'h00;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      skip_cnt_q  <= skip_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      strobe_q    <= strobe_d;
      pressed_q   <= pressed_d;
      code_q      <= code_d;
      dropped_q   <= dropped_d;
    end
  end

  assign bus.strobe  = strobe_q;
  assign bus.pressed = pressed_q;
  assign bus.code    = code_q;
  assign bus.busy    = (state_q == ST_SWEEP);
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: logs every matrix write and checks against hand-built expectations.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_ps2_scan_sequencer;
  localparam logic [15:0] TMO = 16'd8;

  logic clock;
  logic rst_n;
  ps2_scan_sequencer_if bus ();

  ps2_scan_sequencer #(.TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int drop_cnt = 0;
  logic [9:0] ev_q[$];   // {busy, pressed, code}
  int         ts_q[$];

  // Event log of every matrix write and dropped pulse.
  always @(negedge clock) begin
    cyc++;
    if (rst_n && bus.strobe) begin
      ev_q.push_back({bus.busy, bus.pressed, bus.code});
      ts_q.push_back(cyc);
    end
    if (rst_n && bus.dropped) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data   = b;
    bus.rx_strobe = 1'b1;
    @(negedge clock);
    bus.rx_strobe = 1'b0;
  endtask

  task automatic tick_ce(input int n);
    bus.ce = 1'b1;
    repeat (n) @(negedge clock);
    bus.ce = 1'b0;
  endtask

  task automatic flush_log();
    ev_q.delete();
    ts_q.delete();
  endtask

  // Full release sweep starting at log index base: codes 00..7F, pressed=1,
  // busy high on all but the last write.
  task automatic check_sweep(input string tag, input int base);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      if (base + i >= ev_q.size()) bad++;
      else if (ev_q[base+i] !== {(i < 127), 1'b1, i[7:0]}) bad++;
    end
    chk(tag, bad, 0);
  endtask

  // Log entry (ignoring busy) versus expected {pressed, code}.
  task automatic check_ev(input string tag, input int idx, input logic p, input logic [7:0] c);
    logic [8:0] got;
    got = (idx < ev_q.size()) ? ev_q[idx][8:0] : 9'h1FF;
    chk(tag, got, {p, c});
  endtask

  initial begin
    int bad;
    bit seen;
    rst_n         = 1'b0;
    bus.ce        = 1'b0;
    bus.rx_strobe = 1'b0;
    bus.rx_data   = 8'h00;
    bus.clear     = 1'b0;
    idle(3);

    // reset values
    chk("rst_strobe",  bus.strobe, 0);
    chk("rst_pressed", bus.pressed, 1);
    chk("rst_code",    bus.code, 8'h00);
    chk("rst_busy",    bus.busy, 1);
    chk("rst_dropped", bus.dropped, 0);

    // power-on sweep
    rst_n = 1'b1;
    idle(135);
    chk("por_count", ev_q.size(), 128);
    check_sweep("por_sweep", 0);
    chk("por_busy_low", bus.busy, 0);
    if (ts_q.size() > 0) chk("por_first_edge", ts_q[0], 4);
    flush_log();

    // make and break
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    idle(3);
    chk("mk_brk_count", ev_q.size(), 2);
    check_ev("make_1c", 0, 1'b0, 8'h1C);
    check_ev("break_1c", 1, 1'b1, 8'h1C);
    flush_log();
    send_byte(8'hF0);
    send_byte(8'hAA);
    idle(3);
    chk("f0_aa_silent", ev_q.size(), 0);

    // extended codes
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h14);
    idle(3);
    chk("ext_count", ev_q.size(), 3);
    check_ev("ext_make_75", 0, 1'b0, 8'h75);
    check_ev("ext_brk_75", 1, 1'b1, 8'h75);
    check_ev("ext_make_14", 2, 1'b0, 8'h14);
    flush_log();

    // pause sequence swallowed
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    send_byte(8'h16);
    idle(3);
    chk("pause_count", ev_q.size(), 1);
    check_ev("pause_then_16", 0, 1'b0, 8'h16);
    flush_log();

    // prefix timeout: one tick short keeps the break, full timeout abandons it
    send_byte(8'hF0);
    tick_ce(int'(TMO) - 1);
    send_byte(8'h16);
    idle(2);
    send_byte(8'hF0);
    tick_ce(int'(TMO));
    send_byte(8'h16);
    idle(3);
    chk("tmo_count", ev_q.size(), 2);
    check_ev("tmo_short", 0, 1'b1, 8'h16);
    check_ev("tmo_expired", 1, 1'b0, 8'h16);
    flush_log();

    // overrun mid-prefix, byte held during sweep, second byte dropped
    drop_cnt = 0;
    send_byte(8'hF0);
    send_byte(8'hFF);
    send_byte(8'h16);
    send_byte(8'h1E);
    idle(140);
    chk("ovr_count", ev_q.size(), 129);
    check_sweep("ovr_sweep", 0);
    check_ev("ovr_held_16", 128, 1'b0, 8'h16);
    if (ts_q.size() == 129) chk("ovr_held_timing", ts_q[128] - ts_q[127], 1);
    chk("ovr_dropped", drop_cnt, 1);
    flush_log();

    // clear at code 40 restarts the sweep; a same-cycle byte is held
    drop_cnt = 0;
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (bus.strobe && bus.code == 8'h40) seen = 1'b1;
    end
    chk("clr_reach_40", seen, 1);
    bus.clear     = 1'b1;
    bus.rx_strobe = 1'b1;
    bus.rx_data   = 8'h2D;
    @(negedge clock);
    bus.clear     = 1'b0;
    bus.rx_strobe = 1'b0;
    idle(140);
    chk("clr_count", ev_q.size(), 194);
    bad = 0;
    for (int i = 0; i < 65; i++) begin
      if (i >= ev_q.size() || ev_q[i][8:0] !== {1'b1, i[7:0]}) bad++;
    end
    chk("clr_partial", bad, 0);
    check_sweep("clr_sweep", 65);
    check_ev("clr_held_2d", 193, 1'b0, 8'h2D);
    chk("clr_no_drop", drop_cnt, 0);
    flush_log();

    // acknowledge bytes ignored
    send_byte(8'hAA);
    send_byte(8'hFA);
    send_byte(8'hEE);
    idle(3);
    chk("ack_silent", ev_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
